decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/mips_pkg.sv | 38 +++
 rtl/id_regfile.sv | 41 ++++
 rtl/decode_stage.sv | 167 ++++++++++++++++
 tb/tb_decode_stage.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcodes, ID/EX control-word layout and ALU op encodings.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam int CTRL_REG_WRITE  = 0;
    localparam int CTRL_MEM_READ   = 1;
    localparam int CTRL_MEM_WRITE  = 2;
    localparam int CTRL_MEM_TO_REG = 3;
    localparam int CTRL_ALU_SRC    = 4;
    localparam int CTRL_ALU_OP_LO  = 5;
    localparam int CTRL_W          = 7;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // Field order matches the CTRL_* bit indices above (MSB first).
    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src;
        logic       mem_to_reg;
        logic       mem_write;
        logic       mem_read;
        logic       reg_write;
    } ctrl_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/id_regfile.sv
// 32x32 register file: synchronous write, combinational reads with same-cycle write bypass; $0 reads 0.
module id_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic [4:0]  ra_addr,
    input  logic [4:0]  rb_addr,
    output logic [31:0] ra_data,
    output logic [31:0] rb_data
);

    logic [31:0] regs [32];
    logic        wb_live;

    assign wb_live = wb_en && (wb_addr != 5'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_live) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // A write landing this edge is visible to the instruction decoding now.
    always_comb begin
        ra_data = '0;
        rb_data = '0;
        if (ra_addr != 5'd0) begin
            ra_data = (wb_live && wb_addr == ra_addr) ? wb_data : regs[ra_addr];
        end
        if (rb_addr != 5'd0) begin
            rb_data = (wb_live && wb_addr == rb_addr) ? wb_data : regs[rb_addr];
        end
    end

endmodule

// File: rtl/decode_stage.sv
// MIPS ID stage: decode, register read, load-use/branch hazard stall, early branch resolve, ID/EX register.
module decode_stage
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] if_id,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        exmem_reg_write,
    input  logic        exmem_mem_read,
    input  logic [4:0]  exmem_dst,
    input  logic [31:0] exmem_alu_result,
    output logic        stall,
    output logic        branch_sel,
    output logic [31:0] branch_target,
    output logic [6:0]  idex_ctrl,
    output logic [31:0] idex_pc4,
    output logic [31:0] idex_rs_data,
    output logic [31:0] idex_rt_data,
    output logic [31:0] idex_imm,
    output logic [4:0]  idex_rs,
    output logic [4:0]  idex_rt,
    output logic [4:0]  idex_dst
);

    logic [31:0] pc4;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm_ext;

    assign pc4     = if_id[63:32];
    assign instr   = if_id[31:0];
    assign opcode  = instr[31:26];
    assign rs      = instr[25:21];
    assign rt      = instr[20:16];
    assign rd      = instr[15:11];
    assign imm_ext = sext16(instr[15:0]);

    ctrl_t      ctrl_d;
    logic [4:0] dst_d;
    logic       uses_rt;
    logic       is_branch;
    logic       is_jump;

    always_comb begin
        ctrl_d    = '0;
        dst_d     = '0;
        uses_rt   = 1'b0;
        is_branch = 1'b0;
        is_jump   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_op    = ALU_FUNCT;
                dst_d            = rd;
                uses_rt          = 1'b1;
            end
            OP_LW: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.mem_read   = 1'b1;
                ctrl_d.mem_to_reg = 1'b1;
                ctrl_d.alu_src    = 1'b1;
                ctrl_d.alu_op     = ALU_ADD;
                dst_d             = rt;
            end
            OP_SW: begin
                ctrl_d.mem_write = 1'b1;
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.alu_op    = ALU_ADD;
                uses_rt          = 1'b1;
            end
            OP_ADDI: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.alu_op    = ALU_ADD;
                dst_d            = rt;
            end
            OP_BEQ, OP_BNE: begin
                is_branch = 1'b1;
                uses_rt   = 1'b1;
            end
            OP_J: is_jump = 1'b1;
            default: ;
        endcase
        // Writes to $0 are discarded here so later hazard checks never match it.
        if (dst_d == 5'd0) begin
            ctrl_d.reg_write = 1'b0;
        end
    end

    logic [31:0] rs_data;
    logic [31:0] rt_data;

    id_regfile u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .ra_addr (rs),
        .rb_addr (rt),
        .ra_data (rs_data),
        .rb_data (rt_data)
    );

    logic load_use;
    logic br_hazard;
    logic hazard;
    logic fwd_ok;
    logic [31:0] cmp_a;
    logic [31:0] cmp_b;
    logic taken;

    assign load_use = idex_ctrl[CTRL_MEM_READ] && (idex_dst != 5'd0) &&
                      ((idex_dst == rs) || (uses_rt && idex_dst == rt));

    // Branches compare in ID, so a result still in EX, or a load in MEM, is not yet available.
    assign br_hazard = is_branch &&
        ((idex_ctrl[CTRL_REG_WRITE] && (idex_dst != 5'd0) &&
          ((idex_dst == rs) || (idex_dst == rt))) ||
         (exmem_mem_read && (exmem_dst != 5'd0) &&
          ((exmem_dst == rs) || (exmem_dst == rt))));

    assign hazard = load_use || br_hazard;

    assign fwd_ok = exmem_reg_write && (exmem_dst != 5'd0);
    assign cmp_a  = (fwd_ok && exmem_dst == rs) ? exmem_alu_result : rs_data;
    assign cmp_b  = (fwd_ok && exmem_dst == rt) ? exmem_alu_result : rt_data;

    assign taken = ((opcode == OP_BEQ) && (cmp_a == cmp_b)) ||
                   ((opcode == OP_BNE) && (cmp_a != cmp_b)) ||
                   is_jump;

    assign stall         = rst_n && hazard;
    assign branch_sel    = rst_n && !hazard && taken;
    assign branch_target = is_jump ? {pc4[31:28], instr[25:0], 2'b00}
                                   : pc4 + {imm_ext[29:0], 2'b00};

    // A stall loads a bubble; the stalled instruction is re-decoded from the held IF/ID.
    always_ff @(posedge clk) begin
        if (!rst_n || hazard) begin
            idex_ctrl    <= '0;
            idex_pc4     <= '0;
            idex_rs_data <= '0;
            idex_rt_data <= '0;
            idex_imm     <= '0;
            idex_rs      <= '0;
            idex_rt      <= '0;
            idex_dst     <= '0;
        end else begin
            idex_ctrl    <= ctrl_d;
            idex_pc4     <= pc4;
            idex_rs_data <= rs_data;
            idex_rt_data <= rt_data;
            idex_imm     <= imm_ext;
            idex_rs      <= rs;
            idex_rt      <= rt;
            idex_dst     <= dst_d;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: ID/EX packets scored through an expected queue, hazard/branch outputs checked inline.
module tb_decode_stage;

    localparam int PKT_W = 150;

    localparam logic [6:0] C_R    = 7'b1000001;
    localparam logic [6:0] C_NOP  = 7'b1000000;
    localparam logic [6:0] C_LW   = 7'b0011011;
    localparam logic [6:0] C_ADDI = 7'b0010001;

    logic        clk;
    logic        rst_n;
    logic [63:0] if_id;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        exmem_reg_write;
    logic        exmem_mem_read;
    logic [4:0]  exmem_dst;
    logic [31:0] exmem_alu_result;
    logic        stall;
    logic        branch_sel;
    logic [31:0] branch_target;
    logic [6:0]  idex_ctrl;
    logic [31:0] idex_pc4;
    logic [31:0] idex_rs_data;
    logic [31:0] idex_rt_data;
    logic [31:0] idex_imm;
    logic [4:0]  idex_rs;
    logic [4:0]  idex_rt;
    logic [4:0]  idex_dst;

    decode_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_id            (if_id),
        .wb_en            (wb_en),
        .wb_addr          (wb_addr),
        .wb_data          (wb_data),
        .exmem_reg_write  (exmem_reg_write),
        .exmem_mem_read   (exmem_mem_read),
        .exmem_dst        (exmem_dst),
        .exmem_alu_result (exmem_alu_result),
        .stall            (stall),
        .branch_sel       (branch_sel),
        .branch_target    (branch_target),
        .idex_ctrl        (idex_ctrl),
        .idex_pc4         (idex_pc4),
        .idex_rs_data     (idex_rs_data),
        .idex_rt_data     (idex_rt_data),
        .idex_imm         (idex_imm),
        .idex_rs          (idex_rs),
        .idex_rt          (idex_rt),
        .idex_dst         (idex_dst)
    );

    // Clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [PKT_W-1:0] exp_q[$];
    logic [PKT_W-1:0] obs_pkt;
    logic [31:0] r3_val;

    assign obs_pkt = {idex_ctrl, idex_rs, idex_rt, idex_dst, idex_pc4,
                      idex_rs_data, idex_rt_data, idex_imm};

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic check(input string tag, input logic [PKT_W-1:0] obs, input logic [PKT_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic drive(input logic [31:0] instr, input logic [31:0] pc4);
        if_id = {pc4, instr};
        #1;
    endtask

    task automatic tick();
        logic [PKT_W-1:0] exp;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL idex_queue: observed no pending entry expected one");
        end else begin
            exp = exp_q.pop_front();
            check("idex_pkt", obs_pkt, exp);
        end
    endtask

    // Expected ID/EX contents for the instruction currently in IF/ID.
    task automatic expect_idex(input logic [6:0] ctrl, input logic [4:0] dst,
                               input logic [31:0] rsd, input logic [31:0] rtd);
        logic [31:0] imm;
        imm = {{16{if_id[15]}}, if_id[15:0]};
        exp_q.push_back({ctrl, if_id[25:21], if_id[20:16], dst, if_id[63:32], rsd, rtd, imm});
        tick();
    endtask

    task automatic expect_bubble();
        exp_q.push_back('0);
        tick();
    endtask

    task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
        drive(32'd0, 32'd0);
        wb_en   = 1'b1;
        wb_addr = addr;
        wb_data = data;
        expect_idex(C_NOP, 5'd0, 32'd0, 32'd0);
        wb_en = 1'b0;
    endtask

    initial begin
        rst_n            = 1'b0;
        if_id            = '0;
        wb_en            = 1'b0;
        wb_addr          = '0;
        wb_data          = '0;
        exmem_reg_write  = 1'b0;
        exmem_mem_read   = 1'b0;
        exmem_dst        = '0;
        exmem_alu_result = '0;
        r3_val           = 32'($urandom_range(256, 65535));

        // Power-on reset
        drive(r_type(5'd1, 5'd2, 5'd3), 32'h4);
        expect_bubble();
        rst_n = 1'b1;

        write_reg(5'd1, 32'd7);
        write_reg(5'd2, 32'd7);
        write_reg(5'd3, r3_val);

        // Same-cycle write-back bypass, and $0 ignoring writes
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
        drive(r_type(5'd5, 5'd0, 5'd3), 32'h8);
        expect_idex(C_R, 5'd3, 32'h1234, 32'd0);
        wb_addr = 5'd0; wb_data = 32'hdead;
        drive(r_type(5'd0, 5'd5, 5'd3), 32'hc);
        expect_idex(C_R, 5'd3, 32'd0, 32'h1234);
        wb_en = 1'b0;

        // Load-use: one bubble then the consumer
        drive(i_type(6'h23, 5'd1, 5'd2, 16'd0), 32'h10);
        expect_idex(C_LW, 5'd2, 32'd7, 32'd7);
        drive(r_type(5'd2, 5'd3, 5'd4), 32'h14);
        check("lu_stall", PKT_W'(stall), PKT_W'(1'b1));
        check("lu_bsel", PKT_W'(branch_sel), PKT_W'(1'b0));
        expect_bubble();
        check("lu_release", PKT_W'(stall), PKT_W'(1'b0));
        expect_idex(C_R, 5'd4, 32'd7, r3_val);

        // Load then addi writing the loaded register: rt not a source, no stall
        drive(i_type(6'h23, 5'd1, 5'd2, 16'd0), 32'h18);
        expect_idex(C_LW, 5'd2, 32'd7, 32'd7);
        drive(i_type(6'h08, 5'd3, 5'd2, 16'd1), 32'h1c);
        check("addi_no_stall", PKT_W'(stall), PKT_W'(1'b0));
        expect_idex(C_ADDI, 5'd2, r3_val, 32'd7);
        drive(32'd0, 32'h20);
        expect_idex(C_NOP, 5'd0, 32'd0, 32'd0);

        // Branches resolved from the register file
        drive(i_type(6'h04, 5'd1, 5'd2, 16'd3), 32'h44);
        check("beq_stall", PKT_W'(stall), PKT_W'(1'b0));
        check("beq_taken", PKT_W'(branch_sel), PKT_W'(1'b1));
        check("beq_target", PKT_W'(branch_target), PKT_W'(32'h50));
        expect_idex(7'd0, 5'd0, 32'd7, 32'd7);
        drive(i_type(6'h05, 5'd1, 5'd2, 16'd3), 32'h44);
        check("bne_equal", PKT_W'(branch_sel), PKT_W'(1'b0));
        expect_idex(7'd0, 5'd0, 32'd7, 32'd7);
        drive(i_type(6'h04, 5'd1, 5'd3, 16'hfffe), 32'h100);
        check("beq_unequal", PKT_W'(branch_sel), PKT_W'(1'b0));
        check("beq_neg_target", PKT_W'(branch_target), PKT_W'(32'hf8));
        expect_idex(7'd0, 5'd0, 32'd7, r3_val);
        drive(i_type(6'h05, 5'd1, 5'd3, 16'hfffe), 32'h100);
        check("bne_taken", PKT_W'(branch_sel), PKT_W'(1'b1));
        expect_idex(7'd0, 5'd0, 32'd7, r3_val);

        // Branch behind a producing addi: stall, then forwarded compare
        drive(i_type(6'h08, 5'd0, 5'd1, 16'd7), 32'h40);
        expect_idex(C_ADDI, 5'd1, 32'd0, 32'd7);
        drive(i_type(6'h04, 5'd1, 5'd2, 16'd3), 32'h44);
        check("bh_stall", PKT_W'(stall), PKT_W'(1'b1));
        check("bh_bsel_masked", PKT_W'(branch_sel), PKT_W'(1'b0));
        expect_bubble();
        exmem_reg_write = 1'b1; exmem_dst = 5'd1; exmem_alu_result = 32'd7;
        #1;
        check("bh_release", PKT_W'(stall), PKT_W'(1'b0));
        check("bh_fwd_taken", PKT_W'(branch_sel), PKT_W'(1'b1));
        check("bh_target", PKT_W'(branch_target), PKT_W'(32'h50));
        exmem_alu_result = 32'd8;
        #1;
        check("bh_fwd_rs_diff", PKT_W'(branch_sel), PKT_W'(1'b0));
        exmem_dst = 5'd2; exmem_alu_result = 32'd9;
        #1;
        check("bh_fwd_rt_diff", PKT_W'(branch_sel), PKT_W'(1'b0));
        exmem_reg_write = 1'b0;
        #1;
        check("bh_no_fwd", PKT_W'(branch_sel), PKT_W'(1'b1));
        expect_idex(7'd0, 5'd0, 32'd7, 32'd7);

        // Branch behind a load in MEM
        exmem_mem_read = 1'b1; exmem_dst = 5'd2;
        drive(i_type(6'h05, 5'd1, 5'd2, 16'd1), 32'h48);
        check("bm_stall", PKT_W'(stall), PKT_W'(1'b1));
        expect_bubble();
        exmem_mem_read = 1'b0;
        #1;
        check("bm_release", PKT_W'(stall), PKT_W'(1'b0));
        expect_idex(7'd0, 5'd0, 32'd7, 32'd7);

        // Jump
        drive({6'h02, 26'h100}, 32'h00400004);
        check("j_taken", PKT_W'(branch_sel), PKT_W'(1'b1));
        check("j_target", PKT_W'(branch_target), PKT_W'(32'h00000400));
        expect_idex(7'd0, 5'd0, 32'd0, 32'd0);

        // Reset mid-stream overrides stall and write-back
        exmem_mem_read = 1'b1; exmem_dst = 5'd1;
        rst_n = 1'b0;
        drive(i_type(6'h04, 5'd1, 5'd2, 16'd3), 32'h44);
        check("rst_stall", PKT_W'(stall), PKT_W'(1'b0));
        check("rst_bsel", PKT_W'(branch_sel), PKT_W'(1'b0));
        exmem_mem_read = 1'b0; exmem_dst = 5'd0;
        drive(r_type(5'd5, 5'd0, 5'd3), 32'h8);
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'hffff;
        expect_bubble();
        wb_en = 1'b0;
        rst_n = 1'b1;
        for (int r = 0; r < 32; r++) begin
            drive(r_type(5'(r), 5'(r), 5'd0), 32'd0);
            expect_idex(C_NOP, 5'd0, 32'd0, 32'd0);
        end

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL idex_queue_drain: observed %0d left expected 0", exp_q.size());
        end
        // Final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
